// File: rtl/call_stack_if.sv
// Handshake bundle for call_stack: call/return strobes and pushed address in,
// top-of-stack, occupancy and sticky error status out.
interface call_stack_if #(
    parameter int CNTR_WIDTH    = 8,
    parameter int STACK_BIT_CNT = 3
);
    logic                    cal_f;
    logic                    ret_f;
    logic                    clr_err;
    logic [CNTR_WIDTH-1:0]   counter;
    logic [CNTR_WIDTH-1:0]   ret_addr;
    logic [STACK_BIT_CNT:0]  depth;
    logic                    empty;
    logic                    full;
    logic                    ovf_err;
    logic                    unf_err;

    modport master (
        output cal_f, ret_f, clr_err, counter,
        input  ret_addr, depth, empty, full, ovf_err, unf_err
    );

    modport slave (
        input  cal_f, ret_f, clr_err, counter,
        output ret_addr, depth, empty, full, ovf_err, unf_err
    );
endinterface

// File: rtl/call_stack.sv
// Return-address stack for the sequencer: circular register file with top pointer and depth count.
// Define CALL_STACK_WRAP_EN to make a push while full overwrite the oldest entry instead of being rejected.
module call_stack #(
    parameter int CNTR_WIDTH    = 8,
    parameter int STACK_BIT_CNT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    call_stack_if.slave  bus
);
    localparam int DEPTH = 1 << STACK_BIT_CNT;
    localparam int PTR_W = (STACK_BIT_CNT > 0) ? STACK_BIT_CNT : 1;
    localparam logic [STACK_BIT_CNT:0] FULL_CNT = (STACK_BIT_CNT + 1)'(DEPTH);

    logic [CNTR_WIDTH-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]       top;
    logic [PTR_W-1:0]       top_inc;
    logic [PTR_W-1:0]       top_dec;
    logic [STACK_BIT_CNT:0] cnt;
    logic                   ovf_q;
    logic                   unf_q;
    logic                   is_empty;
    logic                   is_full;
`ifdef CALL_STACK_WRAP_EN
    logic [PTR_W-1:0]       bot;
    logic [PTR_W-1:0]       bot_inc;
`endif

    // With a single entry the pointer has no real bits, so it is pinned at zero.
    function automatic logic [PTR_W-1:0] ptr_step(input logic [PTR_W-1:0] p, input logic up);
        logic [PTR_W-1:0] r;
        if (DEPTH == 1)
            r = '0;
        else if (up)
            r = p + 1'b1;
        else
            r = p - 1'b1;
        return r;
    endfunction

    assign top_inc  = ptr_step(top, 1'b1);
    assign top_dec  = ptr_step(top, 1'b0);
`ifdef CALL_STACK_WRAP_EN
    assign bot_inc  = ptr_step(bot, 1'b1);
`endif
    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == FULL_CNT);

    assign bus.ret_addr = is_empty ? '0 : mem[top];
    assign bus.depth    = cnt;
    assign bus.empty    = is_empty;
    assign bus.full     = is_full;
    assign bus.ovf_err  = ovf_q;
    assign bus.unf_err  = unf_q;

    // Error sets are written after the clear so a coincident new error wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            top   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
`ifdef CALL_STACK_WRAP_EN
            bot   <= '0;
`endif
        end else begin
            if (bus.clr_err) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end
            case ({bus.cal_f, bus.ret_f})
                2'b10: begin
                    if (!is_full) begin
                        mem[top_inc] <= bus.counter;
                        top          <= top_inc;
                        cnt          <= cnt + 1'b1;
`ifdef CALL_STACK_WRAP_EN
                        if (is_empty)
                            bot <= top_inc;
`endif
                    end else begin
                        ovf_q <= 1'b1;
`ifdef CALL_STACK_WRAP_EN
                        mem[top_inc] <= bus.counter;
                        top          <= top_inc;
                        bot          <= bot_inc;
`endif
                    end
                end
                2'b01: begin
                    if (!is_empty) begin
                        top <= top_dec;
                        cnt <= cnt - 1'b1;
                    end else begin
                        unf_q <= 1'b1;
                    end
                end
                // Tail call replaces the top frame; on an empty stack it degrades to a push.
                2'b11: begin
                    if (!is_empty) begin
                        mem[top] <= bus.counter;
                    end else begin
                        mem[top_inc] <= bus.counter;
                        top          <= top_inc;
                        cnt          <= cnt + 1'b1;
                        unf_q        <= 1'b1;
`ifdef CALL_STACK_WRAP_EN
                        bot          <= top_inc;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
Parametrised hardware return-address stack for the sequencer.
- Stores `counter` on every call (`cal_f`) and releases it on every return (`ret_f`).
- Presents the most recent unreturned address on `ret_addr`.
- Supports nested subroutines to depth 2^STACK_BIT_CNT.
- Reports occupancy and sticky overflow/underflow errors to the control unit.

Parameters:
- CNTR_WIDTH, 8, width of program-counter values stored and returned.
- STACK_BIT_CNT, 3, log2 of stack depth; DEPTH = 1<<STACK_BIT_CNT entries.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- cal_f  input  1  call strobe: push `counter` this cycle.
- ret_f  input  1  return strobe: pop top entry this cycle.
- counter  input  CNTR_WIDTH  address to push; the caller supplies the final return address, and no increment is applied inside the block.
- clr_err  input  1  synchronous clear of ovf_err and unf_err.
- ret_addr  output  CNTR_WIDTH  top-of-stack entry; 0 when empty.
- depth  output  STACK_BIT_CNT+1  number of valid entries, 0..DEPTH.
- empty  output  1  depth == 0.
- full  output  1  depth == DEPTH.
- ovf_err  output  1  sticky: a push was attempted while full.
- unf_err  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed): all entries 0, depth 0, pointers 0, ovf_err=0, unf_err=0. This gives ret_addr=0, empty=1, full=0.
- Storage: DEPTH x CNTR_WIDTH register array, addressed as a circular buffer via a top pointer plus depth counter.
- Outputs ret_addr, empty, full and depth are combinational from registered state; they are never combinational from the strobes.
- Latency: a push at edge N makes ret_addr equal the pushed value from edge N onward. A pop at edge N exposes the previous entry from edge N onward.
- Per-edge actions (cal_f, ret_f):
  - 0,0: hold.
  - 1,0, not full: write counter at top+1; top++, depth++.
  - 1,0, full: push rejected, stack unchanged, ovf_err<=1. See the optional feature for the alternative.
  - 0,1, not empty: top--, depth--. The popped entry's contents are don't-care afterwards.
  - 0,1, empty: no change, unf_err<=1.
  - 1,1, not empty: replace. Top entry is overwritten with counter; depth and pointers are unchanged; no error, even when full (tail-call semantics).
  - 1,1, empty: treated as a push of counter; depth becomes 1 and unf_err<=1.
- Pointer arithmetic: modulo DEPTH, wraps naturally at 2^STACK_BIT_CNT. depth is saturated by the full/empty guards and must never exceed DEPTH or underflow.
- Error flags:
  - Sticky until clr_err or reset.
  - If clr_err is asserted in the same cycle as a new error event, set wins and the flag stays 1.
  - clr_err has no effect on stack contents.
- Reset mid-operation: a strobe coincident with rst_n low is discarded. The first edge after rst_n rises acts on the empty stack.
- STACK_BIT_CNT=0 must be legal: DEPTH=1, which is equivalent to a single call register with full/empty tracking.

Optional Feature:
- Macro: CALL_STACK_WRAP_EN.
- Defined: push while full (cal_f=1, ret_f=0) overwrites the oldest entry. top advances, the bottom pointer advances, depth stays DEPTH, and ovf_err<=1. This keeps the most recent DEPTH return addresses, so deep recursion loses the outermost frames.
- Undefined: push while full is rejected as described in Behaviour. The bottom pointer logic is not synthesised.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset, then one push and one pop: reset then check ret_addr=0, empty=1, depth=0. cal_f with counter=0x12 -> ret_addr=0x12, depth=1 next cycle. ret_f -> empty=1, ret_addr=0.
2. Fill and drain, and overflow: with DEPTH=8, push 0x01..0x08 -> full=1, ret_addr=0x08. Push 0x09 -> ovf_err=1, ret_addr=0x08. Eight pops -> ret_addr sequence 0x07..0x01 then 0, empty=1.
   - With CALL_STACK_WRAP_EN: the same push of 0x09 gives ret_addr=0x09; eight pops return 0x08..0x02, and entry 0x01 is lost.
3. Underflow: ret_f on an empty stack -> depth stays 0, unf_err=1. clr_err -> unf_err=0 next cycle. clr_err together with another empty pop -> unf_err stays 1.
4. Simultaneous call and return:
   - Push 0x20, 0x21, then cal_f=ret_f=1 with counter=0x30 -> depth=2, ret_addr=0x30; a pop then gives 0x20.
   - On an empty stack, simultaneous strobes with counter=0x40 -> depth=1, ret_addr=0x40, unf_err=1.
5. Pointer wrap: alternate 3 pushes and 2 pops for 20 iterations, checking against a reference model -> ret_addr and depth match every cycle, ovf_err stays 0 until depth reaches 8.
6. Asynchronous reset mid-stack: with depth=5, drop rst_n between clock edges -> outputs go to reset values immediately. A cal_f held through reset deassertion is discarded only while rst_n is low.
